bloom_op_sequencer: RTL and testbench
=====================================

Name: bloom_op_sequencer

Overview:
- Front-end driver for the counting Bloom filter; this is the initiator side of the filter's Addr/WE/increment/result interface.
- Accepts probe, insert and delete requests from the page-tracking logic over a valid/ready channel and buffers them in a small FIFO.
- Issues one request at a time to the filter, holds the address until the filter result has settled, then returns the hit/miss outcome over a valid/ready response channel.
- Tracks net occupancy so that deletes never underflow the filter counters.

Parameters:
ADDR_W, 57, width of request/filter address (bits [56:0])
RESULT_LAT, 2, cycles from issue cycle to sampling bf_result (range 1..15)
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
OCC_W, 16, width of occupancy counter

Ports:
CLK  in  1  clock, all state on rising edge
rstb  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO not full
req_op  in  2  00 probe, 01 insert, 10 delete, 11 reserved
req_addr  in  ADDR_W  physical address of request
bf_addr  out  ADDR_W  address to filter Addr
bf_we  out  1  to filter WE
bf_inc  out  1  to filter increment (1 = increment, 0 = decrement)
bf_result  in  1  filter result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_hit  out  1  sampled bf_result (0 on error)
rsp_op  out  2  echo of request op
rsp_err  out  1  reserved op or delete-at-zero-occupancy
occupancy  out  OCC_W  inserts minus deletes actually issued
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (rstb=0, async): FIFO empty, FSM=IDLE, bf_addr=0, bf_we=0, bf_inc=0, rsp_valid=0, rsp_hit=0, rsp_op=0, rsp_err=0, occupancy=0, req_ready=1.
- Reset mid-operation aborts the in-flight op; no response is produced. The filter shares rstb and clears together with this block.
- Request accept: a request is accepted when req_valid && req_ready at the clock edge. req_ready = !full, combinational from FIFO state only.
- Simultaneous push and pop when full: the push is still refused. req_ready does not look ahead.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into op registers.
    - op==11, or op==10 with occupancy==0: go to RESP with rsp_err=1, rsp_hit=0. Nothing is driven to the filter.
    - otherwise: go to ISSUE.
  - ISSUE (exactly 1 cycle): bf_addr=op addr; bf_we=1 for insert/delete, 0 for probe; bf_inc=1 only for insert. Occupancy is updated at the end of this cycle: +1 insert, -1 delete. Occupancy saturates at 2^OCC_W-1; inserts at saturation are still issued. Go to WAIT with lat_cnt=RESULT_LAT-1.
  - WAIT: bf_we=0, bf_inc=0, bf_addr held. Decrement lat_cnt. When lat_cnt==0, sample bf_result into rsp_hit and go to RESP. With RESULT_LAT=1, WAIT lasts 1 cycle.
  - RESP: rsp_valid=1 and all rsp_* stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE. bf_addr is held through RESP.
- Throughput: one op per (RESULT_LAT+3) cycles minimum (IDLE, ISSUE, WAIT x RESULT_LAT, RESP). Ops are never overlapped, because the filter zero/OF state is updated only after a write.
- bf_we is asserted for exactly one cycle per insert/delete. It is never asserted for probes or error ops.
- Ordering: responses are returned in request order. The occupancy check for a delete uses the value after all earlier ops have issued.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are detected by the MSB compare; pointers wrap modulo 2*FIFO_DEPTH.

Decomposition:
- Shared package bloom_pkg:
  - op encodings OP_PROBE=2'b00, OP_INSERT=2'b01, OP_DELETE=2'b10, OP_RSVD=2'b11
  - FSM state enum {IDLE, ISSUE, WAIT, RESP}
  - ADDR_W and PageOffset constants shared with the filter
- Sub-module bloom_req_fifo: synchronous FIFO of {op, addr}, same CLK/rstb, push/pop/full/empty, parameter FIFO_DEPTH.

Test Plan:
- Insert 0x0000_0000_0001_2000, then probe the same address with rsp_ready=1 → insert response rsp_err=0. Probe response rsp_hit matches the filter model with bf_result=1. occupancy=1. bf_we high for exactly 1 cycle with bf_inc=1.
- Delete at reset (occupancy=0) → rsp_err=1, rsp_hit=0, bf_we never asserted, occupancy stays 0.
- Push 5 requests back-to-back with rsp_ready=0 and FIFO_DEPTH=4 → req_ready drops after the 4th FIFO entry plus 1 in flight. Releasing rsp_ready returns all responses in order with correct rsp_op.
- Set RESULT_LAT=3 and toggle bf_result each cycle → rsp_hit equals the bf_result value exactly 3 cycles after the ISSUE cycle. bf_addr is stable from ISSUE through RESP.
- Op 11 → rsp_err=1, no filter access. The following insert proceeds normally.
- Assert rstb=0 during WAIT of an insert → all outputs return to reset values immediately (async). No response is emitted. occupancy=0 and FIFO is empty after release.

Source files
------------

// File: rtl/bloom_pkg.sv
// Shared definitions for the counting Bloom filter front end: op codes,
// sequencer states and address constants common with the filter itself.
package bloom_pkg;

  localparam int ADDR_W      = 57;
  localparam int PAGE_OFFSET = 12;
  localparam int LAT_W       = 4;

  typedef enum logic [1:0] {
    OP_PROBE  = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Inserts and deletes modify filter counters; probes only read.
  function automatic logic op_writes(input logic [1:0] op);
    return (op == OP_INSERT) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/bloom_req_fifo.sv
// Request buffer between the page-tracking logic and the sequencer FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bloom_req_fifo #(
  parameter int W          = 59,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         rstb,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [W-1:0]     mem_d [FIFO_DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/bloom_op_sequencer.sv
// Initiator for the counting Bloom filter: serialises probe/insert/delete
// requests, waits out the filter latency and returns one response per request.
module bloom_op_sequencer #(
  parameter int ADDR_W     = bloom_pkg::ADDR_W,
  parameter int RESULT_LAT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int OCC_W      = 16
) (
  input  logic              CLK,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] bf_addr,
  output logic              bf_we,
  output logic              bf_inc,
  input  logic              bf_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [1:0]        rsp_op,
  output logic              rsp_err,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  import bloom_pkg::*;

  // Handshake: a request transfers on a rising CLK edge where req_valid and
  // req_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. rsp_* hold steady while rsp_valid waits.

  localparam int FW = ADDR_W + 2;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] bf_addr_q, bf_addr_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              rsp_err_q, rsp_err_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [FW-1:0]     fifo_head;
  logic [1:0]        head_op;
  logic [ADDR_W-1:0] head_addr;
  logic              head_err;

  bloom_req_fifo #(
    .W          (FW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .CLK       (CLK),
    .rstb      (rstb),
    .push      (req_valid),
    .push_data ({req_op, req_addr}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_op   = fifo_head[FW-1:ADDR_W];
  assign head_addr = fifo_head[ADDR_W-1:0];
  // Occupancy is settled here: the previous op has always issued before IDLE.
  assign head_err  = (head_op == OP_RSVD) ||
                     ((head_op == OP_DELETE) && (occ_q == '0));
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      bf_addr_q <= '0;
      lat_cnt_q <= '0;
      occ_q     <= '0;
      rsp_hit_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      bf_addr_q <= bf_addr_d;
      lat_cnt_q <= lat_cnt_d;
      occ_q     <= occ_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bf_addr_d = bf_addr_q;
    lat_cnt_d = lat_cnt_q;
    occ_d     = occ_q;
    rsp_hit_d = rsp_hit_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          op_d = head_op;
          if (head_err) begin
            rsp_err_d = 1'b1;
            rsp_hit_d = 1'b0;
            state_d   = RESP;
          end else begin
            rsp_err_d = 1'b0;
            bf_addr_d = head_addr;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_INSERT) begin
          if (occ_q != '1) begin
            occ_d = occ_q + OCC_W'(1);
          end
        end else if (op_q == OP_DELETE) begin
          occ_d = occ_q - OCC_W'(1);
        end
        lat_cnt_d = LAT_W'(RESULT_LAT - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_hit_d = bf_result;
          state_d   = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = !fifo_full;
    bf_addr   = bf_addr_q;
    bf_we     = (state_q == ISSUE) && op_writes(op_q);
    bf_inc    = (state_q == ISSUE) && (op_q == OP_INSERT);
    rsp_valid = (state_q == RESP);
    rsp_hit   = rsp_hit_q;
    rsp_op    = op_q;
    rsp_err   = rsp_err_q;
    occupancy = occ_q;
    busy      = (state_q != IDLE) || !fifo_empty;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_bloom_op_sequencer.sv
// Self-checking bench for bloom_op_sequencer: randomized requests, a
// cycle-level behavioural model of the request/response timing rules.
module tb_bloom_op_sequencer;

  localparam int AW    = 57;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int OW    = 16;

  logic          CLK = 1'b0;
  logic          rstb = 1'b0;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] bf_addr;
  logic          bf_we, bf_inc, bf_result;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [1:0]    rsp_op;
  logic [OW-1:0] occupancy;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 CLK = ~CLK;

  bloom_op_sequencer #(
    .ADDR_W     (AW),
    .RESULT_LAT (LAT),
    .FIFO_DEPTH (DEPTH),
    .OCC_W      (OW)
  ) dut (
    .CLK       (CLK),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .bf_addr   (bf_addr),
    .bf_we     (bf_we),
    .bf_inc    (bf_inc),
    .bf_result (bf_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_op    (rsp_op),
    .rsp_err   (rsp_err),
    .occupancy (occupancy),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pending requests, the op currently owned by the sequencer, and
  // the cycle it was taken from the queue. Phase = cycles since that pop.
  logic [AW+1:0] exp_q[$];
  bit            m_active = 0;
  int            m_pop = 0;
  logic [1:0]    m_op = 0;
  logic [AW-1:0] m_addr = 0;
  bit            m_err = 0;
  int unsigned   m_occ = 0;
  logic [AW-1:0] m_last_addr = 0;
  bit            hist[int];
  int            we_cnt = 0;
  int            rsp_cnt = 0;
  logic          last_err = 0;
  logic          last_hit = 0;

  int          rdy_mode = 1;
  bit          tog_mode = 0;

  always @(negedge CLK) begin : cmp
    logic e_we, e_inc, e_valid, e_busy, e_hit;
    bit   was;
    int   ph, start_size;
    logic [AW+1:0] d;
    if (!rstb) begin
      exp_q.delete();
      m_active = 0;
      m_occ = 0;
      m_last_addr = '0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_bf_we", bf_we, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_bf_addr", bf_addr, 0);
    end else begin
      hist[cyc] = bf_result;
      e_we = 0; e_inc = 0; e_valid = 0; ph = 0;
      if (m_active) begin
        ph = cyc - m_pop;
        if (m_err) begin
          e_valid = (ph >= 1);
        end else begin
          if (ph == 1) begin
            e_we = (m_op == 2'b01) || (m_op == 2'b10);
            e_inc = (m_op == 2'b01);
            m_last_addr = m_addr;
          end
          e_valid = (ph >= LAT + 2);
        end
      end
      e_busy = (m_active && ph > 0) || (exp_q.size() > 0);
      check("bf_we", bf_we, e_we);
      check("bf_inc", bf_inc, e_inc);
      check("bf_addr", bf_addr, m_last_addr);
      check("rsp_valid", rsp_valid, e_valid);
      check("req_ready", req_ready, exp_q.size() < DEPTH);
      check("occupancy", occupancy, m_occ);
      check("busy", busy, e_busy);
      if (e_valid) begin
        e_hit = m_err ? 1'b0 : hist[m_pop + 1 + LAT];
        check("rsp_op", rsp_op, m_op);
        check("rsp_err", rsp_err, m_err);
        check("rsp_hit", rsp_hit, e_hit);
      end
      if (bf_we) we_cnt++;
      was = m_active;
      start_size = exp_q.size();
      if (m_active && !m_err && ph == 1) begin
        if (m_op == 2'b01 && m_occ < (1 << OW) - 1) m_occ++;
        else if (m_op == 2'b10) m_occ--;
      end
      if (e_valid && rsp_ready) begin
        m_active = 0;
        rsp_cnt++;
        last_err = rsp_err;
        last_hit = rsp_hit;
      end
      if (!was && start_size > 0) begin
        d = exp_q.pop_front();
        m_op = d[AW+1:AW];
        m_addr = d[AW-1:0];
        m_err = (m_op == 2'b11) || (m_op == 2'b10 && m_occ == 0);
        m_pop = cyc;
        m_active = 1;
      end
      if (req_valid && start_size < DEPTH) exp_q.push_back({req_op, req_addr});
    end
    cyc++;
  end

  // Background drivers for the filter result and the response consumer.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      bf_result = tog_mode ? ~bf_result : 1'($urandom_range(0, 1));
      case (rdy_mode)
        0: rsp_ready = 1'b0;
        1: rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {$urandom(), $urandom()};
    return a;
  endfunction

  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr);
    int k;
    k = 0;
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    forever begin
      @(negedge CLK);
      if (req_ready) break;
      k++;
      if (k > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
      @(posedge CLK);
      #1;
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    forever begin
      @(negedge CLK);
      if (!m_active && exp_q.size() == 0) break;
      k++;
      if (k > 2000) begin
        check("wait_idle_timeout", 1, 0);
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int we0, rc0, acc;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = '0;
    bf_result = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    rstb = 1'b1;
    @(posedge CLK);
    #1;

    // Delete with nothing inserted: error response, filter untouched.
    we0 = we_cnt;
    send(2'b10, 57'h0_0000_0000_5000);
    wait_idle();
    check("t_del0_err", last_err, 1);
    check("t_del0_hit", last_hit, 0);
    check("t_del0_we", we_cnt - we0, 0);
    check("t_del0_occ", occupancy, 0);

    // Insert then probe the same page.
    we0 = we_cnt;
    send(2'b01, 57'h0_0000_0001_2000);
    send(2'b00, 57'h0_0000_0001_2000);
    wait_idle();
    check("t_ins_occ", occupancy, 1);
    check("t_ins_we", we_cnt - we0, 1);
    check("t_probe_err", last_err, 0);

    // Reserved op, then an ordinary insert.
    we0 = we_cnt;
    send(2'b11, rand_addr());
    wait_idle();
    check("t_rsvd_err", last_err, 1);
    check("t_rsvd_we", we_cnt - we0, 0);
    send(2'b01, rand_addr());
    wait_idle();
    check("t_ins2_err", last_err, 0);
    check("t_ins2_we", we_cnt - we0, 1);
    check("t_ins2_occ", occupancy, 2);

    // Stalled consumer: FIFO fills behind one op in flight.
    rdy_mode = 0;
    @(posedge CLK);
    #1;
    rc0 = rsp_cnt;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_op = 2'($urandom_range(0, 2));
      req_addr = rand_addr();
      @(negedge CLK);
      if (req_ready) acc++;
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    check("t_burst_accepts", acc, 5);
    rdy_mode = 1;
    wait_idle();
    check("t_burst_rsps", rsp_cnt - rc0, 5);

    // Random traffic with a randomly stalling consumer.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), rand_addr());
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end
    wait_idle();

    // Toggling filter result pins the sampling cycle.
    rdy_mode = 1;
    tog_mode = 1;
    for (int i = 0; i < 6; i++) begin
      send(2'($urandom_range(0, 1)), rand_addr());
    end
    wait_idle();
    tog_mode = 0;

    // Reset asserted while an insert is waiting on the filter.
    send(2'b01, 57'h0_0000_00AB_C000);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    rc0 = rsp_cnt;
    rstb = 1'b0;
    #1;
    check("t_arst_rsp_valid", rsp_valid, 0);
    check("t_arst_bf_we", bf_we, 0);
    check("t_arst_occ", occupancy, 0);
    check("t_arst_addr", bf_addr, 0);
    check("t_arst_busy", busy, 0);
    check("t_arst_ready", req_ready, 1);
    repeat (2) @(posedge CLK);
    #1;
    rstb = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("t_arst_no_rsp", rsp_cnt - rc0, 0);
    check("t_arst_occ_after", occupancy, 0);
    check("t_arst_idle_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
